// File: rtl/cci_mpf_prim_scoreboard_merge.sv
// Merges the two in-order ports of a dual-port scoreboard into a single
// valid/ready stream. Port 1 has priority. Accepted words are buffered in a
// small ring FIFO whose head is presented first-word fall-through.
module cci_mpf_prim_scoreboard_merge #(
  parameter int N_DATA_BITS      = 64,
  parameter int N_META_BITS      = 1,
  parameter int N_ENTRIES        = 4,
  // Lets a directed test drive both ports ready without stopping simulation.
  parameter bit DUAL_VALID_FATAL = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,

  input  logic                           inNotEmpty  [0:1],
  input  logic [N_DATA_BITS-1:0]         inFirst     [0:1],
  input  logic [N_META_BITS-1:0]         inFirstMeta [0:1],
  output logic                           inDeq_en    [0:1],

  output logic                           outValid,
  output logic [N_DATA_BITS-1:0]         outData,
  output logic [N_META_BITS-1:0]         outMeta,
  input  logic                           outReady,
  output logic [$clog2(N_ENTRIES):0]     outCount,
  output logic                           dualValidErr
);

  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  // Pointer arithmetic relies on natural wrap, so the depth must be 2**k.
  if ((N_ENTRIES < 2) || ((N_ENTRIES & (N_ENTRIES - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "N_ENTRIES must be a power of 2 and at least 2");
  end

  logic [N_DATA_BITS-1:0] data_mem [N_ENTRIES];
  logic [N_META_BITS-1:0] meta_mem [N_ENTRIES];

  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;

  logic                   pop;
  logic                   space;
  logic                   push;
  logic [N_DATA_BITS-1:0] push_data;
  logic [N_META_BITS-1:0] push_meta;

  // Port selection and dequeue strobes; port 1 wins when both are ready.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    inDeq_en[0] = 1'b0;
    inDeq_en[1] = 1'b0;
    push_data   = inFirst[0];
    push_meta   = inFirstMeta[0];

    pop   = outValid && outReady;
    space = (outCount < CNT_W'(N_ENTRIES)) || pop;

    if (inNotEmpty[1]) begin
      inDeq_en[1] = space && reset_n;
      push_data   = inFirst[1];
      push_meta   = inFirstMeta[1];
    end else if (inNotEmpty[0]) begin
      inDeq_en[0] = space && reset_n;
    end

    push = inDeq_en[0] || inDeq_en[1];
  end

  // Head of the FIFO drives the output stream directly from storage.
  always_comb begin
    outValid = (outCount != '0);
    outData  = data_mem[rd_ptr];
    outMeta  = meta_mem[rd_ptr];
  end

  // FIFO storage write port.
  // NOTE: storage has no reset; only pointers and count define which entries are live, so clearing the array would only cost area.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= push_data;
      meta_mem[wr_ptr] <= push_meta;
    end
  end

  // Pointers, occupancy count and the sticky dual-valid flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      outCount     <= '0;
      dualValidErr <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   outCount <= outCount + CNT_W'(1);
        2'b01:   outCount <= outCount - CNT_W'(1);
        default: outCount <= outCount;
      endcase

      if (inNotEmpty[0] && inNotEmpty[1]) dualValidErr <= 1'b1;
    end
  end

  // Both scoreboard ports ready at once means upstream ordering is broken.
  dual_valid_chk : assert property (
    @(posedge clk) disable iff (!reset_n)
      !(DUAL_VALID_FATAL && inNotEmpty[0] && inNotEmpty[1]))
    else $fatal(1, "both inNotEmpty bits high in one cycle");

endmodule

// File: tb/tb_cci_mpf_prim_scoreboard_merge.sv
// Bench for cci_mpf_prim_scoreboard_merge: a directed vector table for the
// pass-through, fill/stall and full-with-pop cases, hand-written sequences
// for dual-valid, random-ready alternation and mid-cycle reset, and a queue
// model that predicts every strobe and head value each cycle.
module tb_cci_mpf_prim_scoreboard_merge;

  localparam int DW = 64;
  localparam int MW = 1;
  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ne   [0:1];
  logic [DW-1:0] fd   [0:1];
  logic [MW-1:0] fm   [0:1];
  logic          deq  [0:1];
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [MW-1:0] out_meta;
  logic          out_ready;
  logic [2:0]    out_count;
  logic          dual_err;

  cci_mpf_prim_scoreboard_merge #(
    .N_DATA_BITS(DW), .N_META_BITS(MW), .N_ENTRIES(NE), .DUAL_VALID_FATAL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .inNotEmpty(ne), .inFirst(fd), .inFirstMeta(fm), .inDeq_en(deq),
    .outValid(out_valid), .outData(out_data), .outMeta(out_meta),
    .outReady(out_ready), .outCount(out_count), .dualValidErr(dual_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: {meta, data} of every word the model expects to be accepted.
  logic [MW+DW-1:0] exp_q [$];
  bit               exp_err;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and let them settle.
  task automatic drive(input bit n0, input bit n1, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input bit rdy);
    @(negedge clk);
    ne[0] = n0; ne[1] = n1;
    fd[0] = d0; fd[1] = d1;
    fm[0] = d0[0]; fm[1] = d1[0];
    out_ready = rdy;
    #1;
  endtask

  // Compare the DUT against the queue model, then advance the model by one edge.
  task automatic model_check(output bit acc);
    int sz    = exp_q.size();
    bit pop_p = (sz != 0) && out_ready;
    bit spc   = (sz < NE) || pop_p;
    bit e1    = ne[1] && spc;
    bit e0    = !ne[1] && ne[0] && spc;
    check("m_deq0", DW'(deq[0]), DW'(e0));
    check("m_deq1", DW'(deq[1]), DW'(e1));
    check("m_valid", DW'(out_valid), DW'(sz != 0));
    check("m_count", DW'(out_count), DW'(sz));
    check("m_err", DW'(dual_err), DW'(exp_err));
    if (sz != 0) begin
      check("m_data", out_data, exp_q[0][DW-1:0]);
      check("m_meta", DW'(out_meta), DW'(exp_q[0][DW+MW-1:DW]));
    end
    if (pop_p) void'(exp_q.pop_front());
    if (e1) exp_q.push_back({fm[1], fd[1]});
    else if (e0) exp_q.push_back({fm[0], fd[0]});
    if (ne[0] && ne[1]) exp_err = 1'b1;
    acc = e0 || e1;
  endtask

  typedef struct {
    bit            n0, n1;
    logic [DW-1:0] d;
    bit            rdy;
    bit            e_deq0, e_deq1, e_valid;
    logic [DW-1:0] e_data;
    int            e_count;
  } vec_t;

  function automatic vec_t mk(bit n0, bit n1, logic [DW-1:0] d, bit rdy,
                              bit q0, bit q1, bit v, logic [DW-1:0] ed, int c);
    vec_t r;
    r.n0 = n0; r.n1 = n1; r.d = d; r.rdy = rdy;
    r.e_deq0 = q0; r.e_deq1 = q1; r.e_valid = v; r.e_data = ed; r.e_count = c;
    return r;
  endfunction

  vec_t vecs [16];

  initial begin
    bit acc;
    int word;
    int next_out;

    // Expected values describe the cycle before the edge on which inputs act.
    vecs[0]  = mk(0, 1, 64'hA5, 1, 0, 1, 0, 0,      0); // empty pass-through
    vecs[1]  = mk(0, 0, 0,      1, 0, 0, 1, 64'hA5, 1);
    vecs[2]  = mk(0, 0, 0,      0, 0, 0, 0, 0,      0);
    vecs[3]  = mk(1, 0, 1,      0, 1, 0, 0, 0,      0); // fill 1..4
    vecs[4]  = mk(1, 0, 2,      0, 1, 0, 1, 1,      1);
    vecs[5]  = mk(1, 0, 3,      0, 1, 0, 1, 1,      2);
    vecs[6]  = mk(1, 0, 4,      0, 1, 0, 1, 1,      3);
    vecs[7]  = mk(1, 0, 5,      0, 0, 0, 1, 1,      4); // full, held off
    vecs[8]  = mk(1, 0, 5,      0, 0, 0, 1, 1,      4);
    vecs[9]  = mk(1, 0, 5,      1, 1, 0, 1, 1,      4); // full: pop 1, push 5
    vecs[10] = mk(0, 0, 0,      1, 0, 0, 1, 2,      4);
    vecs[11] = mk(0, 0, 0,      1, 0, 0, 1, 3,      3);
    vecs[12] = mk(0, 0, 0,      1, 0, 0, 1, 4,      2);
    vecs[13] = mk(0, 0, 0,      1, 0, 0, 1, 5,      1);
    vecs[14] = mk(0, 0, 0,      1, 0, 0, 0, 0,      0); // empty: ready ignored
    vecs[15] = mk(0, 0, 0,      1, 0, 0, 0, 0,      0);

    // Reset state, with port 0 requesting to show the strobe is blocked.
    reset_n = 1'b0;
    ne[0] = 1'b1; ne[1] = 1'b0; fd[0] = '0; fd[1] = '0; fm[0] = '0; fm[1] = '0;
    out_ready = 1'b0;
    exp_err = 1'b0;
    #1;
    check("rst_valid", DW'(out_valid), 0);
    check("rst_count", DW'(out_count), 0);
    check("rst_err",   DW'(dual_err), 0);
    check("rst_deq0",  DW'(deq[0]), 0);
    @(negedge clk);
    ne[0] = 1'b0;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].n0, vecs[i].n1, vecs[i].d, vecs[i].d, vecs[i].rdy);
      check($sformatf("v%0d_deq0", i), DW'(deq[0]), DW'(vecs[i].e_deq0));
      check($sformatf("v%0d_deq1", i), DW'(deq[1]), DW'(vecs[i].e_deq1));
      check($sformatf("v%0d_valid", i), DW'(out_valid), DW'(vecs[i].e_valid));
      check($sformatf("v%0d_count", i), DW'(out_count), DW'(vecs[i].e_count));
      if (vecs[i].e_valid) check($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
      model_check(acc);
    end

    // Dual-valid: only port 1 is dequeued and the flag sticks until reset.
    drive(1, 1, 64'h10, 64'h11, 0);
    check("dv_deq0", DW'(deq[0]), 0);
    check("dv_deq1", DW'(deq[1]), 1);
    check("dv_err_pre", DW'(dual_err), 0);
    model_check(acc);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1);
      check("dv_err_sticky", DW'(dual_err), 1);
      model_check(acc);
    end
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    #1;
    check("dv_err_rst", DW'(dual_err), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Ten words alternating ports under random ready; order must be 0..9.
    word = 0;
    next_out = 0;
    for (int cyc = 0; cyc < 300 && next_out < 10; cyc++) begin
      drive((word < 10) && (word % 2 == 0), (word < 10) && (word % 2 == 1),
            DW'(word), DW'(word), bit'($urandom_range(0, 1)));
      if (out_valid && out_ready) begin
        check("alt_order", out_data, DW'(next_out));
        next_out++;
      end
      model_check(acc);
      if (acc) word++;
    end
    check("alt_all_out", DW'(next_out), 10);

    // Asynchronous reset in the middle of a cycle with three words buffered.
    drive(0, 0, 0, 0, 0);
    model_check(acc);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, DW'(8'h30 + k), 0, 0);
      model_check(acc);
    end
    drive(0, 0, 0, 0, 0);
    check("ar_count_pre", DW'(out_count), 3);
    model_check(acc);
    @(posedge clk);
    #3;
    ne[0] = 1'b0; ne[1] = 1'b0; out_ready = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("ar_valid", DW'(out_valid), 0);
    check("ar_count", DW'(out_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 64'h77, 0, 1);
    model_check(acc);
    drive(0, 0, 0, 0, 1);
    check("ar_first", out_data, 64'h77);
    check("ar_first_valid", DW'(out_valid), 1);
    model_check(acc);
    drive(0, 0, 0, 0, 1);
    model_check(acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
